// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and width helper for the buffered UART transmitter
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered show-ahead read data
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr + 1'b1;

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // dout always holds the head entry, so a pop never waits on a RAM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
            if (do_pop) begin
                if (count > CW'(1)) begin
                    dout <= mem[rd_next];
                end else if (do_push) begin
                    dout <= din;
                end
            end else if (empty && do_push) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - buffered UART transmitter with per-frame parity and stop-bit selection
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_two_stop,
    output logic                              tx_out,
    output logic                              busy,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int BW = clog2(CLKS_PER_BIT);
    localparam int DW = clog2(DATA_BITS);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] BIT_LAST  = DW'(DATA_BITS - 1);

    tx_state_t            state, state_n;
    logic [BW-1:0]        baud_cnt, baud_n;
    logic [DW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 parity_bit, parity_n;
    logic                 par_en, par_en_n;
    logic                 two_stop, two_stop_n;
    logic                 stop_cnt, stop_n;
    logic                 tx_n;
    logic                 busy_n;
    logic                 push;
    logic                 pop;
    logic                 bit_tick;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    assign s_ready  = !fifo_full;
    assign push     = s_valid && s_ready;
    assign bit_tick = (baud_cnt == BAUD_LAST);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n    = state;
        baud_n     = bit_tick ? '0 : baud_cnt + 1'b1;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        parity_n   = parity_bit;
        par_en_n   = par_en;
        two_stop_n = two_stop;
        stop_n     = stop_cnt;
        pop        = 1'b0;

        case (state)
            ST_IDLE: begin
                baud_n = '0;
                pop    = !fifo_empty;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = par_en ? ST_PARITY : ST_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_n = ST_STOP;
                    stop_n  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (two_stop && !stop_cnt) begin
                        stop_n = 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // framing options are latched with the word so mid-frame config edits wait for the next frame
        if (pop) begin
            state_n    = ST_START;
            shreg_n    = fifo_dout;
            parity_n   = (^fifo_dout) ^ (cfg_parity == PARITY_ODD);
            par_en_n   = (cfg_parity == PARITY_ODD) || (cfg_parity == PARITY_EVEN);
            two_stop_n = cfg_two_stop;
        end

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
            ST_PARITY: tx_n = parity_n;
            default:   tx_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE) || push ||
                 (!fifo_empty && !(pop && (fifo_count == CW'(1))));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            par_en     <= 1'b0;
            two_stop   <= 1'b0;
            stop_cnt   <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            parity_bit <= parity_n;
            par_en     <= par_en_n;
            two_stop   <= two_stop_n;
            stop_cnt   <= stop_n;
            tx_out     <= tx_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - directed self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] s_data8;
    logic       s_valid8, s_ready8;
    logic [1:0] cfg_parity8;
    logic       cfg_two_stop8;
    logic       tx8, busy8;
    logic [2:0] count8;

    logic [4:0] s_data5;
    logic       s_valid5, s_ready5;
    logic [1:0] cfg_parity5;
    logic       cfg_two_stop5;
    logic       tx5, busy5;
    logic [2:0] count5;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
        .cfg_parity(cfg_parity8), .cfg_two_stop(cfg_two_stop8), .tx_out(tx8), .busy(busy8),
        .fifo_count(count8)
    );

    uart_tx_fifo_param #(.DATA_BITS(5), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .reset(reset), .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5),
        .cfg_parity(cfg_parity5), .cfg_two_stop(cfg_two_stop5), .tx_out(tx5), .busy(busy5),
        .fifo_count(count5)
    );

    function automatic logic [63:0] expand(input logic [15:0] bits, input int nper);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nper * 4; i++) r[i] = bits[i / 4];
        return r;
    endfunction

    task automatic capture(input int which, input int n, output logic [63:0] line);
        line = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line[i] = (which == 5) ? tx5 : tx8;
        end
    endtask

    task automatic push8(input logic [7:0] d);
        s_data8 = d;
        s_valid8 = 1'b1;
        @(posedge clk);
        #1;
        s_valid8 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++; if (tx8 !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", tx8); end
        tests_run++; if (s_ready8 !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready: got %b want 1", s_ready8); end
        tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy8); end
        tests_run++; if (count8 !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count8); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: tx %b busy %b want 1 0", tx8, busy8); end
        tests_run++; if (tx5 !== 1'b1 || s_ready5 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_dut5: tx %b s_ready %b want 1 1", tx5, s_ready5); end
    endtask

    task automatic test_8n1;
        logic [63:0] line, want;
        push8(8'hA5);
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1) begin tests_failed++; $display("FAIL 8n1_latency_tx: got %b want 1", tx8); end
        tests_run++; if (busy8 !== 1'b1 || count8 !== 3'd1) begin tests_failed++; $display("FAIL 8n1_after_push: busy %b count %0d want 1 1", busy8, count8); end
        capture(8, 40, line);
        want = expand({1'b1, 8'hA5, 1'b0}, 10);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL 8n1_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || count8 !== 3'd0) begin tests_failed++; $display("FAIL 8n1_end: tx %b busy %b count %0d want 1 0 0", tx8, busy8, count8); end
    endtask

    task automatic test_parity;
        logic [63:0] l1, l2, line, want;
        cfg_parity8 = PARITY_EVEN;
        push8(8'h07);
        @(negedge clk);
        capture(8, 20, l1);
        cfg_parity8 = PARITY_ODD;
        capture(8, 24, l2);
        line = l1 | (l2 << 20);
        want = expand({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL even_parity_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL even_parity_end: tx %b busy %b want 1 0", tx8, busy8); end
        push8(8'h07);
        @(negedge clk);
        capture(8, 44, line);
        want = expand({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL odd_parity_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL odd_parity_end: tx %b busy %b want 1 0", tx8, busy8); end
        cfg_parity8 = PARITY_NONE;
    endtask

    task automatic test_two_stop;
        logic [63:0] line, want;
        cfg_two_stop8 = 1'b1;
        push8(8'h00);
        @(negedge clk);
        capture(8, 44, line);
        want = expand({2'b11, 8'h00, 1'b0}, 11);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL two_stop_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL two_stop_end: tx %b busy %b want 1 0", tx8, busy8); end
        cfg_two_stop8 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [6];
        int         exp_edge [6];
        logic [2:0] exp_cnt [6];
        logic       exp_rdy [6];
        logic       line_b [242];
        int         cyc, g, bad, first_bad, f, c, p;
        logic       e;
        words    = '{8'h01, 8'h80, 8'h3C, 8'hFF, 8'h00, 8'h96};
        exp_edge = '{1, 2, 3, 4, 5, 43};
        exp_cnt  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    s_data8 = words[i];
                    s_valid8 = 1'b1;
                    g = 0;
                    while (s_ready8 !== 1'b1 && g < 300) begin
                        @(negedge clk);
                        cyc++;
                        g++;
                    end
                    if (g >= 300) begin
                        tests_run++; tests_failed++;
                        $display("FAIL burst_timeout: word %0d not accepted within 300 cycles", i);
                        break;
                    end
                    @(negedge clk);
                    cyc++;
                    tests_run++; if (cyc != exp_edge[i]) begin tests_failed++; $display("FAIL burst_accept_edge[%0d]: got %0d want %0d", i, cyc, exp_edge[i]); end
                    tests_run++; if (count8 !== exp_cnt[i]) begin tests_failed++; $display("FAIL burst_count[%0d]: got %0d want %0d", i, count8, exp_cnt[i]); end
                    tests_run++; if (s_ready8 !== exp_rdy[i]) begin tests_failed++; $display("FAIL burst_s_ready[%0d]: got %b want %b", i, s_ready8, exp_rdy[i]); end
                end
                s_valid8 = 1'b0;
            end
            begin
                for (int j = 0; j < 242; j++) begin
                    @(negedge clk);
                    line_b[j] = tx8;
                end
            end
        join
        bad = 0;
        first_bad = -1;
        for (int j = 1; j <= 240; j++) begin
            f = (j - 1) / 40;
            c = (j - 1) % 40;
            p = c / 4;
            if (p == 0) e = 1'b0;
            else if (p == 9) e = 1'b1;
            else e = words[f][p - 1];
            if (line_b[j] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = j;
            end
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL burst_line: %0d bad cycles, first at %0d, want 0", bad, first_bad); end
        tests_run++; if (line_b[0] !== 1'b1 || line_b[241] !== 1'b1) begin tests_failed++; $display("FAIL burst_idle_edges: got %b %b want 1 1", line_b[0], line_b[241]); end
        tests_run++; if (busy8 !== 1'b0 || count8 !== 3'd0) begin tests_failed++; $display("FAIL burst_end: busy %b count %0d want 0 0", busy8, count8); end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] line, want;
        push8(8'hC3);
        s_data8 = 8'h81;
        s_valid8 = 1'b1;
        @(posedge clk);
        #1;
        s_valid8 = 1'b0;
        repeat (18) @(negedge clk);
        tests_run++; if (tx8 !== 1'b0 || count8 !== 3'd1) begin tests_failed++; $display("FAIL mid_frame_before_reset: tx %b count %0d want 0 1", tx8, count8); end
        reset = 1'b1;
        #1;
        tests_run++; if (tx8 !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_tx: got %b want 1", tx8); end
        tests_run++; if (count8 !== 3'd0 || s_ready8 !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_fifo: count %0d s_ready %b want 0 1", count8, s_ready8); end
        tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b want 0", busy8); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL after_reset_quiet: tx %b busy %b want 1 0", tx8, busy8); end
        push8(8'h5A);
        @(negedge clk);
        capture(8, 40, line);
        want = expand({1'b1, 8'h5A, 1'b0}, 10);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL after_reset_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin tests_failed++; $display("FAIL after_reset_end: tx %b busy %b want 1 0", tx8, busy8); end
    endtask

    task automatic test_five_bit;
        logic [63:0] line, want;
        s_data5 = 5'h1F;
        s_valid5 = 1'b1;
        @(posedge clk);
        #1;
        s_valid5 = 1'b0;
        @(negedge clk);
        tests_run++; if (tx5 !== 1'b1 || busy5 !== 1'b1) begin tests_failed++; $display("FAIL five_bit_latency: tx %b busy %b want 1 1", tx5, busy5); end
        capture(5, 28, line);
        want = expand({1'b1, 5'h1F, 1'b0}, 7);
        tests_run++; if (line !== want) begin tests_failed++; $display("FAIL five_bit_line: got %h want %h", line, want); end
        @(negedge clk);
        tests_run++; if (tx5 !== 1'b1 || busy5 !== 1'b0) begin tests_failed++; $display("FAIL five_bit_end: tx %b busy %b want 1 0", tx5, busy5); end
    endtask

    initial begin
        reset = 1'b1;
        s_data8 = '0;
        s_valid8 = 1'b0;
        cfg_parity8 = PARITY_NONE;
        cfg_two_stop8 = 1'b0;
        s_data5 = '0;
        s_valid5 = 1'b0;
        cfg_parity5 = PARITY_NONE;
        cfg_two_stop5 = 1'b0;
        test_reset;
        test_8n1;
        test_parity;
        test_two_stop;
        test_back_to_back;
        test_reset_mid_frame;
        test_five_bit;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised, buffered UART transmitter for the host link. Accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first with start, optional parity and 1 or 2 stop bits. Runs entirely in the `clk` domain: bit timing comes from a clock-enable counter, not a derived clock. It replaces the fixed 8N1 single-word transmitter on the result path of the matrix-multiply UART link.

## Interface
- `DATA_BITS`, default 8: frame data width, legal 5–9.
- `CLKS_PER_BIT`, default 434: `clk` cycles per bit (100 MHz / 230400). Must be at least 2.
- `FIFO_DEPTH`, default 16: FIFO entries, a power of two and at least 2.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high.
- `s_data` input DATA_BITS: word to transmit.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: FIFO can accept a word (`!full`).
- `cfg_parity` input 2: parity mode. `00` none, `01` odd, `10` even, `11` is treated as none.
- `cfg_two_stop` input 1: 1 selects two stop bits, 0 selects one.
- `tx_out` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` output clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- **Reset values:** `tx_out`=1, `s_ready`=1, `busy`=0, `fifo_count`=0, FSM in IDLE, baud counter 0, FIFO empty.
- **Push:** a word is pushed on any edge where `s_valid && s_ready`. `s_ready` is registered as `!full`.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - Pushing while full is impossible because `s_ready`=0.
- **Config capture:** `cfg_parity` and `cfg_two_stop` are captured at pop time and held for the whole frame. Mid-frame changes affect only the next frame.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → (START | IDLE).
  - **IDLE:** `tx_out`=1. If the FIFO is non-empty: pop into the shift register, capture config, compute parity, and go to START.
  - **START:** `tx_out`=0 for CLKS_PER_BIT cycles.
  - **DATA:** drives `shreg[0]`, shifting right once per bit period. Runs DATA_BITS bit periods, then goes to PARITY if parity is enabled, otherwise to STOP.
  - **PARITY:** drives the parity bit. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - **STOP:** `tx_out`=1 for 1 or 2 bit periods. At the end of the last stop period, a non-empty FIFO pops and goes directly to START with no idle gap; an empty FIFO returns to IDLE.
- **Baud counter:** runs 0..CLKS_PER_BIT-1 and resets to 0 on every state entry from IDLE. The bit boundary is when the counter reaches CLKS_PER_BIT-1.
- **Bit counter:** counts data bits 0..DATA_BITS-1 and is cleared on entry to DATA.
- **`busy`:** `(state != IDLE) || !empty`, registered.

## Timing
- **Push to line:** word pushed at edge k into an empty FIFO in IDLE. The FIFO is non-empty after edge k, the pop happens at edge k+1, and `tx_out` falls after edge k+1. Latency is 1 cycle.
- **Frame length:** (1 + DATA_BITS + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the final stop cycle.
- **`fifo_count` / `s_ready`:** both update on the edge following the push or pop.
- **Reset mid-frame:** `tx_out` goes to 1 asynchronously, the FIFO is flushed, and the partial frame is dropped with no completion.

## Structure
- **Package `uart_pkg`:** parity mode constants `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`, FSM state encoding, and a `clog2` helper.
- **Sub-module `uart_sync_fifo`:** parametrised by WIDTH and DEPTH. Ports: push, pop, din, dout, full, empty, count. Uses a registered read with show-ahead `dout`.
- **Top level:** FSM, baud counter, bit counter, shift register and parity logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **8N1, 0xA5:** `tx_out` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. 40 cycles total. `busy` deasserts on the cycle after the stop bit.
- **Even parity, 0x07:** parity bit = 1. **Odd parity, 0x07:** parity bit = 0. Frame = 44 cycles. `cfg_parity` changed mid-frame does not alter the current parity bit.
- **Two stop bits, 0x00:** 8 low bits follow the start bit, then high for 8 cycles. Frame = 44 cycles.
- **Burst with `FIFO_DEPTH`=4:** 6 back-to-back pushes. `s_ready` falls after the 5th accept (one word is already popped). Frames are contiguous with no idle cycle, and `fifo_count` tracks occupancy exactly.
- **Reset at cycle 17 of a frame:** `tx_out`=1 immediately, `fifo_count`=0, `s_ready`=1. A new push after reset transmits cleanly.
- **`DATA_BITS`=5, 0x1F, no parity:** `tx_out` = 0,1,1,1,1,1,1, 28 cycles total.
